mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one mux4 datapath between four requesters.
//   It samples a 4-bit request vector and issues a one-hot grant.
//   It drives the mux4 select lines (s1, s0) so that z0 carries the granted
//   requester's d-input.
//   Each grant is bounded by a slot length, so no requester can starve the
//   others.
//
// PARAMETERS
//   SLOT_CYCLES  4  max consecutive cycles one grant is held while others
//                   request; legal range 1..15
//   CNT_W        4  width of the slot counter; must hold SLOT_CYCLES-1
//
// PORTS
//   clk     in   1  system clock (12 MHz board clock)
//   rst     in   1  reset; synchronous, active-high
//   req     in   4  request vector; req[i] = requester i wants mux input di
//   gnt     out  4  one-hot grant, registered; 0000 = no owner
//   s1      out  1  mux4 select MSB, registered
//   s0      out  1  mux4 select LSB, registered
//   active  out  1  high while any grant is asserted (|gnt)
//
// BEHAVIOUR
//   Clock and reset
//   - Single clock, clk.
//   - rst is synchronous and active-high: sampled on the rising clk edge only.
//   Reset values (next edge with rst=1, including mid-grant)
//   - state=IDLE, gnt=0000, s1=0, s0=0, active=0, ptr=0, cnt=0.
//   Round-robin pointer
//   - ptr (2 bit) names the highest-priority requester.
//   - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   - On every new grant to index j: ptr <= (j+1) mod 4.
//   State IDLE
//   - req==0000: stay in IDLE, gnt=0000; s1/s0 hold their last value.
//   - req!=0000: next edge grants the first set bit in search order.
//     gnt <= onehot(j); {s1,s0} <= j; cnt <= 0; go to GRANT.
//     Latency from req sampled to gnt visible is 1 cycle.
//   State GRANT (owner i), evaluated each edge in this priority:
//     a) req[i]==0 (release), other requests pending:
//        grant the next in search order from i+1 on the same edge.
//        No idle bubble; cnt <= 0.
//     b) req[i]==0, no other requests: go to IDLE, gnt <= 0000.
//        s1/s0 hold i.
//     c) cnt==SLOT_CYCLES-1 and any req[k], k!=i:
//        preempt to the next requester after i; cnt <= 0.
//     d) otherwise keep gnt; cnt <= cnt+1, saturating at SLOT_CYCLES-1.
//        A lone requester therefore holds the grant indefinitely.
//   Simultaneous events
//   - Release and slot expiry on the same edge are handled as release (a/b).
//   - New requests arriving during a grant wait; they never interrupt
//     before slot expiry.
//   Output rules
//   - gnt is always one-hot or zero.
//   - {s1,s0} always equals the index of the set gnt bit while active=1.
//   - No combinational path from req to any output.
//   - SLOT_CYCLES=1: rotate every cycle under full load.
//
// TESTING
//   1. rst=1 for 3 cycles with req=1111 -> gnt=0000, s1s0=00 throughout.
//      First edge after rst=0 -> gnt=0001, s1s0=00.
//   2. req=0100 only -> one cycle later gnt=0100, s1s0=10, active=1.
//      Held for 20 cycles; cnt saturates, no drop.
//   3. req=1111 constant, SLOT_CYCLES=4 -> gnt 0001,0010,0100,1000,0001...
//      Each exactly 4 cycles, no 0000 gap, s1s0 tracks 00,01,10,11.
//   4. req=0011, owner 0; drop req[0] after 2 cycles -> next edge gnt=0010,
//      s1s0=01, cnt restarts at 0.
//   5. Owner 3 (req=1000) drops -> gnt=0000, active=0, s1s0 stays 11.
//      Then req=1001 -> gnt=0001 (ptr=0).
//   6. rst=1 mid-GRANT (owner 2, cnt=2) -> next edge gnt=0000, active=0.
//      After release with req=1111 -> gnt=0001.
//   All: a bench mux4 driven by s1/s0 has z0 == d[owner] whenever active=1.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the shared mux4 arbiter.
// The master side drives the request vector. The slave side (the arbiter) returns
// the grant and the mux select lines.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       active;

  modport master (output req, input gnt, s1, s0, active);
  modport slave  (input req, output gnt, s1, s0, active);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4 datapath between four requesters.
// It issues a registered one-hot grant and drives the matching mux select {s1,s0}.
// A slot counter limits how long one owner keeps the grant while others wait.
module mux4_rr_arbiter #(
  parameter int SLOT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [3:0]       req;
  logic [3:0]       others;
  logic [1:0]       idle_idx;
  logic [1:0]       rot_idx;

  // Convert a 2-bit index into a one-hot vector.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Find the first set bit of r, searching start, start+1, ... (mod 4).
  // The loop runs downwards so that the nearest hit is assigned last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] cand;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (r[cand]) res = cand;
    end
    return res;
  endfunction

  assign req      = bus.req;
  // The other requesters are everyone except the current owner (sel_q in GRANT).
  assign others   = req & ~onehot(sel_q);
  assign idle_idx = rr_pick(req, ptr_q);
  assign rot_idx  = rr_pick(others, sel_q + 2'd1);

  // State and output registers. Every output is taken from a flop, so req has no path to an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A release takes priority over slot expiry.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = onehot(idle_idx);
          sel_d   = idle_idx;
          ptr_d   = idle_idx + 2'd1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (|others) begin
            gnt_d = onehot(rot_idx);
            sel_d = rot_idx;
            ptr_d = rot_idx + 2'd1;
            cnt_d = '0;
          end else begin
            // Go idle. The select lines keep pointing at the last owner.
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if ((cnt_q == CNT_MAX) && (|others)) begin
          gnt_d = onehot(rot_idx);
          sel_d = rot_idx;
          ptr_d = rot_idx + 2'd1;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.s1     = sel_q[1];
  assign bus.s0     = sel_q[0];
  assign bus.active = |gnt_q;

endmodule
